// File: rtl/uio_port_arbiter.sv
// Round-robin owner of the shared uio pad bus with a Hi-Z turnaround cycle before every new owner.
// Grant and drive 2 cycles after req, reader data 3 cycles; requesters wait at req until granted.
// Optional forced release of long holders: `define UIO_ARB_TIMEOUT_EN.

module uio_port_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   dir,
  input  logic [8*NREQ-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [7:0]        rdata,
  output logic              rvalid,
  input  logic [7:0]        uio_in,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe
);

  localparam int IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || MAX_HOLD < 1) begin : g_bad_params
    $error("uio_port_arbiter: NREQ must be 2..8 and MAX_HOLD >= 1");
  end

  typedef enum logic [1:0] {IDLE, TURN, OWN} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   own_q, own_d;
  logic            wr_q, wr_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d;
  logic [7:0]      uio_out_q, uio_out_d;
  logic [7:0]      uio_oe_q, uio_oe_d;

  logic [IW-1:0]   win;
  logic            win_found;
  logic [7:0]      own_wdata;
  logic            own_req;
  logic            timeout;

  assign own_wdata = wdata[int'(own_q)*8 +: 8];
  assign own_req   = req[own_q];

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!win_found && req[(int'(ptr_q) + k) % NREQ]) begin
        win_found = 1'b1;
        win       = IW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

`ifdef UIO_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0] hold_q, hold_d;
  logic          others;

  assign others  = |(req & ~({{(NREQ-1){1'b0}}, 1'b1} << own_q));
  // hold_q counts finished OWN cycles, so the current one is hold_q+1.
  assign timeout = (int'(hold_q) + 1 >= MAX_HOLD) && others;

  always_comb begin
    hold_d = hold_q;
    if (state_q == TURN) begin
      hold_d = '0;
    end else if (state_q == OWN && int'(hold_q) < MAX_HOLD) begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= '0;
    else        hold_q <= hold_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    own_d     = own_q;
    wr_d      = wr_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    rdata_d   = rdata_q;
    rvalid_d  = rvalid_q;
    uio_out_d = uio_out_q;
    uio_oe_d  = uio_oe_q;
    case (state_q)
      IDLE: begin
        gnt_d     = '0;
        rdata_d   = '0;
        rvalid_d  = 1'b0;
        uio_out_d = '0;
        uio_oe_d  = '0;
        if (ena && win_found) begin
          own_d   = win;
          wr_d    = dir[win];
          ptr_d   = win;
          state_d = TURN;
        end
      end
      TURN: begin
        state_d   = OWN;
        gnt_d     = {{(NREQ-1){1'b0}}, 1'b1} << own_q;
        rvalid_d  = 1'b0;
        uio_oe_d  = wr_q ? 8'hFF : 8'h00;
        uio_out_d = wr_q ? own_wdata : 8'h00;
      end
      OWN: begin
        if (!own_req || timeout) begin
          state_d   = IDLE;
          gnt_d     = '0;
          rdata_d   = '0;
          rvalid_d  = 1'b0;
          uio_out_d = '0;
          uio_oe_d  = '0;
        end else if (wr_q) begin
          uio_out_d = own_wdata;
        end else begin
          rdata_d  = uio_in;
          rvalid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      own_q     <= '0;
      wr_q      <= 1'b0;
      ptr_q     <= IW'(NREQ - 1);
      gnt_q     <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      uio_out_q <= '0;
      uio_oe_q  <= '0;
    end else begin
      state_q   <= state_d;
      own_q     <= own_d;
      wr_q      <= wr_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      uio_out_q <= uio_out_d;
      uio_oe_q  <= uio_oe_d;
    end
  end

  assign gnt     = gnt_q;
  assign rdata   = rdata_q;
  assign rvalid  = rvalid_q;
  assign uio_out = uio_out_q;
  assign uio_oe  = uio_oe_q;

endmodule
